// File: rtl/pipe_ctrl.sv
// pipe_ctrl - pipeline sequencer for the 5-stage core.
//
// Produces the decode-stage bubble (hazard), the squash (flush), the global
// freeze on an outstanding data-memory access (stall_mem) and the PC hold
// (stall_if).  Sequences taken-branch and interrupt flushes, owns the
// mem_ack wait with a timeout, and tracks the in-handler state until rti
// retires.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   rd_en_ex, write_reg_ex           load in EX and its destination
//   rs1_if_id, rs2_if_id             sources of the instruction in IF/ID
//   branch_taken                     EX redirect pulse
//   mem_req, mem_ack                 MEM stage access / completion
//   irq, rti_ex                      level interrupt, return-from-interrupt
//   hazard, flush, stall_mem,        combinational pipeline controls
//   stall_if, int_take
//   int_active, mem_err              registered status
//
// state     | meaning
// ----------+----------------------------------------------------------
// RUN       | normal issue; redirects and interrupts are accepted here
// MEM_WAIT  | memory access outstanding, pipeline frozen until ack/timeout
// FLUSH     | squashing the wrong-path instructions after a redirect

module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_en_ex,
    input  logic [4:0] write_reg_ex,
    input  logic [4:0] rs1_if_id,
    input  logic [4:0] rs2_if_id,
    input  logic       branch_taken,
    input  logic       mem_req,
    input  logic       mem_ack,
    input  logic       irq,
    input  logic       rti_ex,
    output logic       hazard,
    output logic       flush,
    output logic       stall_mem,
    output logic       stall_if,
    output logic       int_take,
    output logic       int_active,
    output logic       mem_err
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // The redirect cycle itself is the first flushed cycle, so the FLUSH
    // state only has to cover the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [2:0]  FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic        FLUSH_EXTRA  = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;
    localparam logic [15:0] WAIT_LAST    = 16'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        br_pend_q, br_pend_d;
    logic        int_active_q, int_active_d;
    logic        mem_err_q, mem_err_d;
    logic        hazard_q, hazard_d;

    logic is_run, is_wait, is_flush;
    logic timeout_hit, release_c;
    logic ld_use, redirect_run, redirect_rel;
    logic stall_mem_c, int_take_c, flush_c, hazard_c;

    // Output decode
    always_comb begin
        is_run      = (state_q == ST_RUN);
        is_wait     = (state_q == ST_MEM_WAIT);
        is_flush    = (state_q == ST_FLUSH);
        timeout_hit = is_wait & (wcnt_q == WAIT_LAST);

        stall_mem_c = (is_run & mem_req & ~mem_ack)
                    | (is_wait & ~mem_ack & ~timeout_hit);
        release_c   = is_wait & ~stall_mem_c;

        // hazard_q blocks a second bubble for the same load-use pair.
        ld_use = rd_en_ex & (write_reg_ex != 5'd0)
               & ((write_reg_ex == rs1_if_id) | (write_reg_ex == rs2_if_id))
               & ~hazard_q;

        // A pending load-use bubble wins over interrupt entry; using the raw
        // condition here also keeps int_take -> flush -> hazard acyclic.
        int_take_c = irq & ~int_active_q & is_run & ~stall_mem_c
                   & ~branch_taken & ~ld_use;

        redirect_run = is_run & ~stall_mem_c & (branch_taken | int_take_c);
        // A branch parked during the wait is flushed on the release cycle.
        redirect_rel = release_c & (br_pend_q | branch_taken);

        flush_c  = is_flush | redirect_run | redirect_rel;
        hazard_c = ld_use & ~flush_c & ~stall_mem_c;
    end

    // Next-state
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        wcnt_d       = wcnt_q;
        br_pend_d    = br_pend_q;
        mem_err_d    = mem_err_q;
        int_active_d = int_active_q;
        hazard_d     = hazard_c;

        case (state_q)
            ST_RUN: begin
                if (stall_mem_c) begin
                    state_d   = ST_MEM_WAIT;
                    wcnt_d    = 16'd0;
                    br_pend_d = branch_taken;
                end else if (redirect_run && FLUSH_EXTRA) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_RELOAD;
                end
            end
            ST_MEM_WAIT: begin
                if (release_c) begin
                    br_pend_d = 1'b0;
                    if (timeout_hit && !mem_ack) begin
                        mem_err_d = 1'b1;
                    end
                    if (redirect_rel && FLUSH_EXTRA) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FLUSH_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    if (wcnt_q != 16'hFFFF) begin
                        wcnt_d = wcnt_q + 16'd1;
                    end
                    br_pend_d = br_pend_q | branch_taken;
                end
            end
            ST_FLUSH: begin
                // fcnt holds the flush cycles still owed, this one included.
                if (branch_taken) begin
                    fcnt_d = FLUSH_RELOAD;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = 3'd0;
            end
        endcase

        if (int_take_c) begin
            int_active_d = 1'b1;
        end else if (rti_ex && !stall_mem_c) begin
            int_active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            fcnt_q       <= 3'd0;
            wcnt_q       <= 16'd0;
            br_pend_q    <= 1'b0;
            int_active_q <= 1'b0;
            mem_err_q    <= 1'b0;
            hazard_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            wcnt_q       <= wcnt_d;
            br_pend_q    <= br_pend_d;
            int_active_q <= int_active_d;
            mem_err_q    <= mem_err_d;
            hazard_q     <= hazard_d;
        end
    end

    assign hazard     = hazard_c;
    assign flush      = flush_c;
    assign stall_mem  = stall_mem_c;
    assign stall_if   = hazard_c | stall_mem_c;
    assign int_take   = int_take_c;
    assign int_active = int_active_q;
    assign mem_err    = mem_err_q;

endmodule
